reg_file_wr_arbiter: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/reg_file_wr_arbiter.sv | 94 +++++++++
 tb/tb_reg_file_wr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`timescale 1ns/1ps
// Shared register-file constants and the write-request record.
package reg_file_pkg;

  localparam int DEF_REG_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int NUM_REGS       = 1 << DEF_ADDR_WIDTH;

  // One write request at the default register-file geometry.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_REG_WIDTH-1:0]  data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// Combinational round-robin picker: the first set request bit at or above
// ptr, wrapping upward, wins. Has no state, so a read-port arbiter can reuse it.
module rr_arbiter
  import reg_file_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] idx;

  // Walk the requests from ptr upward and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
`timescale 1ns/1ps
// Shares the register file's single write port among NUM_REQ writers.
// One request is granted per cycle and the winning address and data are
// registered onto the write port one cycle later.
//
// Handshake: a transfer happens in any cycle where i_req_valid[n] and
// o_req_ready[n] are both high. Ready may depend combinationally on valid;
// requesters hold valid, addr and data stable until ready is seen and never
// make valid depend on ready. At most one ready bit is high per cycle, and
// all are low while i_stall or i_rst is high.
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_stall,
  input  logic [NUM_REQ-1:0]                  i_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]                  o_req_ready,
  output logic [ADDR_WIDTH-1:0]               o_reg_addr_w,
  output logic [REG_WIDTH-1:0]                o_reg_val_w,
  output logic                                o_write_en,
  output logic [IDX_W-1:0]                    o_grant_id
);

  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  logic [IDX_W-1:0]      next_ptr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]  sel_data;

  // Stall and reset gate the requests before arbitration, so ready drops
  // in the same cycle and the pointer cannot advance.
  assign eligible = i_req_valid & {NUM_REQ{~(i_stall | i_rst)}};

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign o_req_ready = grant;

  // The winner's slot becomes lowest priority next time.
  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Data mux: pick the granted requester's address and value.
  always_comb begin
    sel_addr = i_req_addr[grant_idx];
    sel_data = i_req_data[grant_idx];
  end

  // Round-robin pointer moves only on a grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= next_ptr;
    end
  end

  // Output stage: the register file always accepts, so it drains every
  // cycle. Address, data and id hold when idle; reset drops a pending write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_write_en   <= 1'b0;
      o_reg_addr_w <= '0;
      o_reg_val_w  <= '0;
      o_grant_id   <= '0;
    end else if (any_grant) begin
      o_write_en   <= 1'b1;
      o_reg_addr_w <= sel_addr;
      o_reg_val_w  <= sel_data;
      o_grant_id   <= grant_idx;
    end else begin
      o_write_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
`timescale 1ns/1ps
// Directed bench for reg_file_wr_arbiter (4 requesters, 32-bit data, 4-bit address).
module tb_reg_file_wr_arbiter;

  logic             clk;
  logic             rst;
  logic             stall;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [3:0]       reg_addr_w;
  logic [31:0]      reg_val_w;
  logic             write_en;
  logic [1:0]       grant_id;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_wr_arbiter #(
    .NUM_REQ    (4),
    .REG_WIDTH  (32),
    .ADDR_WIDTH (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_reg_addr_w (reg_addr_w),
    .o_reg_val_w  (reg_val_w),
    .o_write_en   (write_en),
    .o_grant_id   (grant_id)
  );

  // ---------------- driver tasks ----------------
  // Step to 1 ns after the next rising edge; inputs are driven and outputs
  // sampled there, well away from the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 4'(i + 8);
      req_data[i] = 32'h1111_0000 + i;
    end
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want %b", req_ready, 4'b0000); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", write_en); end
    checks++; if (reg_addr_w !== 4'h0) begin errors++; $display("FAIL reset_addr got %h want 0", reg_addr_w); end
    checks++; if (reg_val_w !== 32'h0) begin errors++; $display("FAIL reset_val got %h want 0", reg_val_w); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", grant_id); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want %b", req_ready, 4'b0001); end
    tick();
    req_valid = 4'b0000;
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL reset_first_we got %b want 1", write_en); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_first_id got %0d want 0", grant_id); end
    checks++; if (reg_addr_w !== 4'h8) begin errors++; $display("FAIL reset_first_addr got %h want 8", reg_addr_w); end
    checks++; if (reg_val_w !== 32'h1111_0000) begin errors++; $display("FAIL reset_first_val got %h want 11110000", reg_val_w); end
    tick();
  endtask

  task automatic test_single;
    req_valid   = 4'b0010;
    req_addr[1] = 4'd3;
    req_data[1] = 32'hDEAD_BEEF;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b want %b", req_ready, 4'b0010); end
    tick();
    req_valid = 4'b0000;
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", write_en); end
    checks++; if (reg_addr_w !== 4'd3) begin errors++; $display("FAIL single_addr got %h want 3", reg_addr_w); end
    checks++; if (reg_val_w !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_val got %h want deadbeef", reg_val_w); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_id got %0d want 1", grant_id); end
    tick();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_idle_we got %b want 0", write_en); end
    checks++; if (reg_addr_w !== 4'd3) begin errors++; $display("FAIL single_hold_addr got %h want 3", reg_addr_w); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_hold_id got %0d want 1", grant_id); end
  endtask

  task automatic test_fairness;
    logic [1:0] exp_q[$];
    logic [1:0] exp_id;
    logic [3:0] exp_ready;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 4'(i + 4);
      req_data[i] = 32'hA000_0000 + i;
    end
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    req_valid = 4'b1111;
    while (exp_q.size() > 0) begin
      exp_id    = exp_q.pop_front();
      exp_ready = 4'b0001 << exp_id;
      #1;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL fair_ready got %b want %b", req_ready, exp_ready); end
      tick();
      checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL fair_we got %b want 1", write_en); end
      checks++; if (grant_id !== exp_id) begin errors++; $display("FAIL fair_id got %0d want %0d", grant_id, exp_id); end
      checks++; if (reg_addr_w !== 4'(exp_id + 4)) begin errors++; $display("FAIL fair_addr got %h want %h", reg_addr_w, 4'(exp_id + 4)); end
      checks++; if (reg_val_w !== 32'hA000_0000 + exp_id) begin errors++; $display("FAIL fair_val got %h want %h", reg_val_w, 32'hA000_0000 + exp_id); end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap_skip;
    do_reset();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_grant2 got %b want %b", req_ready, 4'b0100); end
    tick();
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b want %b", req_ready, 4'b0001); end
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL wrap_id0 got %0d want 0", grant_id); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready1 got %b want %b", req_ready, 4'b0010); end
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL wrap_id1 got %0d want 1", grant_id); end
    // Pointer now sits at 2; with only 0 and 1 valid the search wraps to 0.
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_again got %b want %b", req_ready, 4'b0001); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_stall;
    do_reset();
    req_valid   = 4'b0001;
    req_addr[0] = 4'd9;
    req_data[0] = 32'h0000_0A01;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_pre_ready got %b want %b", req_ready, 4'b0001); end
    tick();
    stall       = 1'b1;
    req_data[0] = 32'h0000_0A02;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall1_ready got %b want 0000", req_ready); end
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL stall1_we got %b want 1", write_en); end
    checks++; if (reg_val_w !== 32'h0000_0A01) begin errors++; $display("FAIL stall1_val got %h want 00000a01", reg_val_w); end
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall2_ready got %b want 0000", req_ready); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL stall2_we got %b want 0", write_en); end
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall3_ready got %b want 0000", req_ready); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL stall3_we got %b want 0", write_en); end
    stall = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_ready got %b want %b", req_ready, 4'b0001); end
    tick();
    req_valid = 4'b0000;
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL stall_release_we got %b want 1", write_en); end
    checks++; if (reg_val_w !== 32'h0000_0A02) begin errors++; $display("FAIL stall_release_val got %h want 00000a02", reg_val_w); end
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 4'(i + 12);
      req_data[i] = 32'h5500_0000 + i;
    end
    req_valid = 4'b1111;
    tick();
    tick();
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL areset_pre_we got %b want 1", write_en); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL areset_pre_id got %0d want 1", grant_id); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL areset_we_drop got %b want 0", write_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL areset_ready got %b want 0000", req_ready); end
    checks++; if (reg_addr_w !== 4'h0) begin errors++; $display("FAIL areset_addr got %h want 0", reg_addr_w); end
    @(posedge clk);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL areset_edge_we got %b want 0", write_en); end
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL areset_post_we got %b want 0", write_en); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL areset_restart got %b want %b", req_ready, 4'b0001); end
    req_valid = 4'b0000;
    tick();
  endtask

  // Bound the whole run in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog timeout reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = 4'b0000;
    req_addr  = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
